// File: rtl/conv_pkg.sv
// -----------------------------------------------------------------------------
// conv_pkg
// Shared types and sizing helpers for the conv front end (pixel sequencer,
// raster counters, line buffer, window/MAC stages).
//   seq_state_t   : pixel sequencer state encoding
//   DEF_*         : default geometry of the conv layer
//   TOTAL_ROWS    : padded rows per frame for the default geometry
//   BEATS_PER_ROW : beats (pixels x channels) per row for the default geometry
//   idx_width()   : index width for a count of n, never narrower than 1 bit
//   total_rows()  : padded row count for a given height and padding
// -----------------------------------------------------------------------------
package conv_pkg;

    localparam int DEF_IN_CHANNELS  = 4;
    localparam int DEF_IMAGE_WIDTH  = 16;
    localparam int DEF_IMAGE_HEIGHT = 16;
    localparam int DEF_DATA_WIDTH   = 16;
    localparam int DEF_PADDING      = 1;

    localparam int TOTAL_ROWS    = DEF_IMAGE_HEIGHT + 2 * DEF_PADDING;
    localparam int BEATS_PER_ROW = DEF_IMAGE_WIDTH * DEF_IN_CHANNELS;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PAD_TOP    = 2'd1,
        STREAM     = 2'd2,
        PAD_BOTTOM = 2'd3
    } seq_state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int total_rows(input int height, input int padding);
        return height + 2 * padding;
    endfunction

endpackage

// File: rtl/raster_counter.sv
// -----------------------------------------------------------------------------
// raster_counter
// Chained channel / column / row counters for a channel-innermost raster scan.
// Each advance steps one beat; ch wraps into col, col wraps into row, row
// wraps to 0 after the last row.
//   clk, rst      : clock, asynchronous active-high reset
//   clear         : synchronous return to position (0,0,0)
//   advance       : step to the next beat
//   ch, col, row  : current position
//   ch_last       : ch is at N_CH-1
//   col_last      : col is at N_COL-1
//   row_last      : row is at N_ROW-1
// -----------------------------------------------------------------------------
module raster_counter
    import conv_pkg::*;
#(
    parameter int N_CH  = DEF_IN_CHANNELS,
    parameter int N_COL = DEF_IMAGE_WIDTH,
    parameter int N_ROW = TOTAL_ROWS
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clear,
    input  logic                        advance,
    output logic [idx_width(N_CH)-1:0]  ch,
    output logic [idx_width(N_COL)-1:0] col,
    output logic [idx_width(N_ROW)-1:0] row,
    output logic                        ch_last,
    output logic                        col_last,
    output logic                        row_last
);

    localparam int CH_W  = idx_width(N_CH);
    localparam int COL_W = idx_width(N_COL);
    localparam int ROW_W = idx_width(N_ROW);

    assign ch_last  = (ch  == CH_W'(N_CH - 1));
    assign col_last = (col == COL_W'(N_COL - 1));
    assign row_last = (row == ROW_W'(N_ROW - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch  <= '0;
            col <= '0;
            row <= '0;
        end else if (clear) begin
            ch  <= '0;
            col <= '0;
            row <= '0;
        end else if (advance) begin
            if (ch_last) begin
                ch <= '0;
                if (col_last) begin
                    col <= '0;
                    row <= row_last ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end else begin
                ch <= ch + 1'b1;
            end
        end
    end

endmodule

// File: rtl/conv_pixel_sequencer.sv
// -----------------------------------------------------------------------------
// conv_pixel_sequencer
// Feeds the conv line buffer: wraps a raster, channel-interleaved feature
// stream with PADDING rows of zeros above and below, one pixel per beat,
// each beat tagged with its padded position and pad-row flags.
//   clk, rst              : clock, asynchronous active-high reset
//   start                 : one-cycle pulse, begins a frame when idle
//   s_pixel/s_valid/s_ready : input feature stream
//   m_pixel/m_valid/m_ready : output stream to the line buffer
//   pad_top, pad_bottom   : current m beat lies in a top / bottom pad row
//   ch_idx, col_idx, row_idx : position of the current m beat (padded row)
//   frame_done            : pulse after the final beat of the frame is taken
//   busy                  : a frame is in progress
// -----------------------------------------------------------------------------
module conv_pixel_sequencer
    import conv_pkg::*;
#(
    parameter int IN_CHANNELS  = DEF_IN_CHANNELS,
    parameter int IMAGE_WIDTH  = DEF_IMAGE_WIDTH,
    parameter int IMAGE_HEIGHT = DEF_IMAGE_HEIGHT,
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int PADDING      = DEF_PADDING
) (
    input  logic                                                  clk,
    input  logic                                                  rst,
    input  logic                                                  start,
    input  logic signed [DATA_WIDTH-1:0]                          s_pixel,
    input  logic                                                  s_valid,
    output logic                                                  s_ready,
    output logic signed [DATA_WIDTH-1:0]                          m_pixel,
    output logic                                                  m_valid,
    input  logic                                                  m_ready,
    output logic                                                  pad_top,
    output logic                                                  pad_bottom,
    output logic [idx_width(IN_CHANNELS)-1:0]                     ch_idx,
    output logic [idx_width(IMAGE_WIDTH)-1:0]                     col_idx,
    output logic [idx_width(total_rows(IMAGE_HEIGHT, PADDING))-1:0] row_idx,
    output logic                                                  frame_done,
    output logic                                                  busy
);

    localparam int N_ROWS = total_rows(IMAGE_HEIGHT, PADDING);
    localparam int CH_W   = idx_width(IN_CHANNELS);
    localparam int COL_W  = idx_width(IMAGE_WIDTH);
    localparam int ROW_W  = idx_width(N_ROWS);

    seq_state_t state;
    // Set once every beat of the frame has been loaded; the register then
    // only waits for the line buffer to take the final beat.
    logic tail;

    logic [CH_W-1:0]  ch_cnt;
    logic [COL_W-1:0] col_cnt;
    logic [ROW_W-1:0] row_cnt;
    logic ch_last, col_last, row_last;

    logic load_en, s_fire, pad_load, advance, region_end, cnt_clear;

    raster_counter #(
        .N_CH  (IN_CHANNELS),
        .N_COL (IMAGE_WIDTH),
        .N_ROW (N_ROWS)
    ) u_raster (
        .clk      (clk),
        .rst      (rst),
        .clear    (cnt_clear),
        .advance  (advance),
        .ch       (ch_cnt),
        .col      (col_cnt),
        .row      (row_cnt),
        .ch_last  (ch_last),
        .col_last (col_last),
        .row_last (row_last)
    );

    // NOTE: every signal driven here gets a value before any branch, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        load_en    = !m_valid || m_ready;
        s_ready    = (state == STREAM) && load_en;
        s_fire     = s_valid && s_ready;
        pad_load   = load_en && ((state == PAD_TOP) || (state == PAD_BOTTOM && !tail));
        advance    = s_fire || pad_load;
        cnt_clear  = (state == IDLE) && start;
        region_end = 1'b0;
        case (state)
            PAD_TOP:    region_end = ch_last && col_last && (row_cnt == ROW_W'(PADDING - 1));
            STREAM:     region_end = ch_last && col_last &&
                                     (row_cnt == ROW_W'(PADDING + IMAGE_HEIGHT - 1));
            PAD_BOTTOM: region_end = ch_last && col_last && row_last;
            default:    region_end = 1'b0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            tail       <= 1'b0;
            m_pixel    <= '0;
            m_valid    <= 1'b0;
            pad_top    <= 1'b0;
            pad_bottom <= 1'b0;
            ch_idx     <= '0;
            col_idx    <= '0;
            row_idx    <= '0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            frame_done <= 1'b0;

            // Output register: take a new beat, or retire the current one
            // when nothing is ready to replace it. Holds while stalled.
            if (advance) begin
                m_pixel    <= s_fire ? s_pixel : '0;
                m_valid    <= 1'b1;
                pad_top    <= (state == PAD_TOP);
                pad_bottom <= (state == PAD_BOTTOM);
                ch_idx     <= ch_cnt;
                col_idx    <= col_cnt;
                row_idx    <= row_cnt;
            end else if (load_en) begin
                m_valid    <= 1'b0;
                pad_top    <= 1'b0;
                pad_bottom <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state <= (PADDING > 0) ? PAD_TOP : STREAM;
                        busy  <= 1'b1;
                    end
                end
                PAD_TOP: begin
                    if (pad_load && region_end) state <= STREAM;
                end
                STREAM: begin
                    // With no bottom padding the last stream beat ends the frame.
                    if (s_fire && region_end) begin
                        state <= PAD_BOTTOM;
                        tail  <= (PADDING == 0);
                    end
                end
                PAD_BOTTOM: begin
                    if (pad_load && region_end) tail <= 1'b1;
                    if (tail && m_valid && m_ready) begin
                        state      <= IDLE;
                        tail       <= 1'b0;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_pixel_sequencer.sv
module tb_conv_pixel_sequencer;
    import conv_pkg::*;

    localparam int DW           = 16;
    localparam int N_IN         = 1024;
    localparam int STARVE_LEN   = 5;
    localparam int CYCLE_BUDGET = 8000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_a = 1'b0, start_b = 1'b0;
    logic signed [DW-1:0] s_pixel = '0;
    logic s_valid = 1'b0;
    logic m_ready = 1'b0;

    // DUT a: PADDING=1, DUT b: PADDING=0
    logic s_ready_a, m_valid_a, pt_a, pb_a, done_a, busy_a;
    logic signed [DW-1:0] pix_a;
    logic [1:0] ch_a;
    logic [3:0] col_a;
    logic [4:0] row_a;
    logic s_ready_b, m_valid_b, pt_b, pb_b, done_b, busy_b;
    logic signed [DW-1:0] pix_b;
    logic [1:0] ch_b;
    logic [3:0] col_b;
    logic [3:0] row_b;

    conv_pixel_sequencer #(.PADDING(1)) dut_a (
        .clk(clk), .rst(rst), .start(start_a),
        .s_pixel(s_pixel), .s_valid(s_valid), .s_ready(s_ready_a),
        .m_pixel(pix_a), .m_valid(m_valid_a), .m_ready(m_ready),
        .pad_top(pt_a), .pad_bottom(pb_a),
        .ch_idx(ch_a), .col_idx(col_a), .row_idx(row_a),
        .frame_done(done_a), .busy(busy_a)
    );

    conv_pixel_sequencer #(.PADDING(0)) dut_b (
        .clk(clk), .rst(rst), .start(start_b),
        .s_pixel(s_pixel), .s_valid(s_valid), .s_ready(s_ready_b),
        .m_pixel(pix_b), .m_valid(m_valid_b), .m_ready(m_ready),
        .pad_top(pt_b), .pad_bottom(pb_b),
        .ch_idx(ch_b), .col_idx(col_b), .row_idx(row_b),
        .frame_done(done_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    // Observed outputs of whichever DUT the current scenario drives
    logic sel = 1'b0;
    logic o_s_ready, o_valid, o_pt, o_pb, o_done, o_busy;
    logic signed [DW-1:0] o_pixel;
    logic [1:0] o_ch;
    logic [3:0] o_col;
    logic [4:0] o_row;

    always_comb begin
        if (sel) begin
            o_s_ready = s_ready_b; o_valid = m_valid_b; o_pt = pt_b; o_pb = pb_b;
            o_done = done_b; o_busy = busy_b; o_pixel = pix_b; o_ch = ch_b;
            o_col = col_b; o_row = {1'b0, row_b};
        end else begin
            o_s_ready = s_ready_a; o_valid = m_valid_a; o_pt = pt_a; o_pb = pb_a;
            o_done = done_a; o_busy = busy_a; o_pixel = pix_a; o_ch = ch_a;
            o_col = col_a; o_row = row_a;
        end
    end

    typedef logic [28:0] beat_bits_t;
    typedef struct {
        beat_bits_t bits;
        bit         last;
    } exp_t;

    typedef struct {
        bit pad0;          // 1: PADDING=0 instance
        int ready_pct;     // m_ready probability in percent
        int starve_at;     // input index where s_valid drops, -1 none
        int busy_start_at; // output beat at which start is re-pulsed, -1 none
        int abort_at;      // output beat at which rst is asserted, -1 none
        int exp_beats;
    } scen_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   beats_seen = 0;
    int   exp_total = 0;
    int   done_cnt = 0;
    bit   mon_en = 1'b0;
    bit   done_exp = 1'b0;
    bit   prev_stall = 1'b0;
    logic [29:0] prev_act = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic beat_bits_t pack_beat(input logic signed [DW-1:0] p, input logic t,
                                             input logic b, input logic [1:0] c,
                                             input logic [3:0] col, input logic [4:0] r);
        return {p, t, b, c, col, r};
    endfunction

    // Reference frame: pad rows of zeros around an incrementing input ramp.
    task automatic build_expected(input bit pad0);
        int   p = pad0 ? 0 : 1;
        int   rows = 16 + 2 * p;
        int   idx = 0;
        exp_t e;
        logic t, b;
        exp_q.delete();
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < 16; c++) begin
                for (int k = 0; k < 4; k++) begin
                    t = (r < p);
                    b = (r >= p + 16);
                    e.bits = pack_beat((t || b) ? DW'(0) : DW'(idx), t, b, 2'(k), 4'(c), 5'(r));
                    e.last = (r == rows - 1) && (c == 15) && (k == 3);
                    if (!(t || b)) idx++;
                    exp_q.push_back(e);
                end
            end
        end
    endtask

    // Scoreboard / protocol monitor, sampling mid-cycle
    always @(negedge clk) begin
        beat_bits_t act;
        exp_t       e;
        act = pack_beat(o_pixel, o_pt, o_pb, o_ch, o_col, o_row);
        if (rst || !mon_en) begin
            done_exp   = 1'b0;
            prev_stall = 1'b0;
        end else begin
            check("frame_done", 64'(o_done), 64'(done_exp));
            if (done_exp) check("busy_after_done", 64'(o_busy), 64'(0));
            done_exp = 1'b0;
            if (prev_stall) check("stall_hold", 64'({o_valid, act}), 64'(prev_act));
            if (o_valid) check("pad_exclusive", 64'(o_pt & o_pb), 64'(0));
            else         check("flags_when_idle", 64'({o_pt, o_pb}), 64'(0));
            if (o_valid && m_ready) begin
                beats_seen++;
                if (exp_q.size() == 0) begin
                    check("extra_beat", 64'(beats_seen), 64'(exp_total));
                end else begin
                    e = exp_q.pop_front();
                    check("beat", 64'(act), 64'(e.bits));
                    done_exp = e.last;
                end
            end
            if (o_done) done_cnt++;
            prev_stall = o_valid && !m_ready;
            prev_act   = {o_valid, act};
        end
    end

    task automatic run_frame(input scen_t sc);
        int in_idx = 0;
        int starve_left = 0;
        int starve_k = 0;
        int resume = 0;
        int cyc = 0;
        int done_before;
        bit starved = 1'b0;
        bit starving_now;
        bit busy_pulsed = 1'b0;
        bit fire;

        sel = sc.pad0;
        build_expected(sc.pad0);
        exp_total   = sc.exp_beats;
        beats_seen  = 0;
        done_before = done_cnt;
        mon_en      = 1'b1;
        if (sc.pad0) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk); #1;

        while (done_cnt == done_before && cyc < CYCLE_BUDGET) begin
            start_a = 1'b0;
            start_b = 1'b0;

            if (sc.abort_at >= 0 && beats_seen >= sc.abort_at) begin
                check("busy_before_rst", 64'(o_busy), 64'(1));
                mon_en = 1'b0;
                #1 rst = 1'b1;
                #1;
                check("rst_outputs", 64'({o_pixel, o_valid, o_pt, o_pb, o_ch, o_col, o_row,
                                          o_done, o_s_ready}), 64'(0));
                check("rst_busy", 64'(o_busy), 64'(0));
                exp_q.delete();
                s_valid = 1'b0;
                m_ready = 1'b0;
                repeat (2) @(posedge clk);
                #1 rst = 1'b0;
                @(posedge clk); #1;
                return;
            end

            m_ready = (sc.ready_pct >= 100) || ($urandom_range(99) < sc.ready_pct);
            starving_now = 1'b0;
            if (sc.starve_at >= 0 && !starved && in_idx == sc.starve_at) begin
                starved     = 1'b1;
                starve_left = STARVE_LEN;
            end
            if (starve_left > 0) begin
                s_valid = 1'b0;
                starve_left--;
                starve_k++;
                starving_now = 1'b1;
            end else begin
                s_valid = (in_idx < N_IN);
                if (starved && resume < 3) resume++;
            end
            s_pixel = DW'(in_idx);
            if (sc.busy_start_at >= 0 && !busy_pulsed && beats_seen >= sc.busy_start_at) begin
                busy_pulsed = 1'b1;
                if (sc.pad0) start_b = 1'b1; else start_a = 1'b1;
            end

            @(negedge clk);
            if (starving_now && starve_k >= 2) begin
                check("starve_valid_low", 64'(o_valid), 64'(0));
                check("starve_ready_high", 64'(o_s_ready), 64'(1));
            end
            if (resume == 1) check("resume_gap", 64'(o_valid), 64'(0));
            if (resume == 2)
                check("resume_beat", 64'({o_valid, o_pixel, o_row, o_col, o_ch}),
                      64'({1'b1, 16'd200, 5'd4, 4'd2, 2'd0}));
            fire = s_valid && o_s_ready;
            @(posedge clk); #1;
            if (fire) in_idx++;
            cyc++;
        end

        start_a = 1'b0;
        start_b = 1'b0;
        s_valid = 1'b0;
        check("frame_completed", 64'(done_cnt - done_before), 64'(1));
        check("beat_count", 64'(beats_seen), 64'(sc.exp_beats));
        check("queue_drained", 64'(exp_q.size()), 64'(0));
        check("inputs_consumed", 64'(in_idx), 64'(N_IN));
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        scen_t tbl[8];
        tbl[0] = '{1'b0, 100, -1,  -1,  -1, 1152}; // nominal frame
        tbl[1] = '{1'b0,  50, -1,  -1,  -1, 1152}; // random backpressure
        tbl[2] = '{1'b0, 100, 200, -1,  -1, 1152}; // input starvation at pixel 200
        tbl[3] = '{1'b1, 100, -1,  -1,  -1, 1024}; // PADDING=0
        tbl[4] = '{1'b0, 100, -1,  300, -1, 1152}; // start pulse while busy
        tbl[5] = '{1'b0, 100, -1,  -1, 500, 1152}; // reset mid-frame
        tbl[6] = '{1'b0, 100, -1,  -1,  -1, 1152}; // full replay after reset
        tbl[7] = '{1'b1,  50, -1,  -1,  -1, 1024}; // PADDING=0 with backpressure

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state_a", 64'({pix_a, m_valid_a, pt_a, pb_a, ch_a, col_a, row_a,
                                    done_a, busy_a, s_ready_a}), 64'(0));
        check("reset_state_b", 64'({pix_b, m_valid_b, pt_b, pb_b, ch_b, col_b, row_b,
                                    done_b, busy_b, s_ready_b}), 64'(0));
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_after_reset", 64'({busy_a, s_ready_a, m_valid_a}), 64'(0));

        for (int i = 0; i < 8; i++) run_frame(tbl[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
